// File: rtl/rdma_req_arb_ul_if.sv
// Request-path bundle for rdma_req_arb_ul: N_CHAN input channels
// merged onto one output; slave is the arbiter view, master the requester view.
interface rdma_req_arb_ul_if #(
   parameter int N_CHAN    = 4,
   parameter int DATA_BITS = 96
);
   localparam int CHAN_BITS = $clog2(N_CHAN);

   logic [N_CHAN-1:0]           s_req_valid;
   logic [N_CHAN-1:0]           s_req_ready;
   logic [N_CHAN*DATA_BITS-1:0] s_req_data;
   logic                        m_req_valid;
   logic                        m_req_ready;
   logic [DATA_BITS-1:0]        m_req_data;
   logic [CHAN_BITS-1:0]        m_req_chan;

   modport slave (
      input  s_req_valid, s_req_data, m_req_ready,
      output s_req_ready, m_req_valid, m_req_data, m_req_chan
   );

   modport master (
      output s_req_valid, s_req_data, m_req_ready,
      input  s_req_ready, m_req_valid, m_req_data, m_req_chan
   );
endinterface

// File: rtl/rdma_req_arb_ul.sv
// Per-channel FIFOs feeding a round-robin arbiter and one output register.
// Define RDMA_REQ_STATS_EN to build the per-channel granted-beat counters.
module rdma_req_arb_ul #(
   parameter int N_CHAN    = 4,
   parameter int DATA_BITS = 96,
   parameter int DEPTH     = 8,
   localparam int CHAN_BITS = $clog2(N_CHAN),
   localparam int CNT_BITS  = $clog2(DEPTH) + 1,
   localparam int PTR_BITS  = $clog2(DEPTH)
) (
   input  logic                       aclk,
   input  logic                       areset,
   rdma_req_arb_ul_if.slave           bus,
   output logic [N_CHAN*32-1:0]       stat_grant_cnt,
   output logic [N_CHAN*CNT_BITS-1:0] fifo_fill
);
   typedef logic [DATA_BITS-1:0] data_t;

   data_t                mem_q  [N_CHAN][DEPTH];
   data_t                mem_d  [N_CHAN][DEPTH];
   logic [PTR_BITS-1:0]  wptr_q [N_CHAN];
   logic [PTR_BITS-1:0]  wptr_d [N_CHAN];
   logic [PTR_BITS-1:0]  rptr_q [N_CHAN];
   logic [PTR_BITS-1:0]  rptr_d [N_CHAN];
   logic [CNT_BITS-1:0]  fill_q [N_CHAN];
   logic [CNT_BITS-1:0]  fill_d [N_CHAN];
   logic [N_CHAN-1:0]    rdy_q, rdy_d;
   logic [N_CHAN-1:0]    push, pop;
   logic                 ov_q, ov_d;
   data_t                data_q, data_d;
   logic [CHAN_BITS-1:0] chan_q, chan_d;
   logic [CHAN_BITS-1:0] last_q, last_d;
   logic                 load, found;
   logic [CHAN_BITS-1:0] gnt;

   // Round-robin search starting just after the last winner.
   always_comb begin
      int c;
      logic [CHAN_BITS-1:0] cidx;
      found = 1'b0;
      gnt   = '0;
      for (int k = 1; k <= N_CHAN; k++) begin
         c    = (int'(last_q) + k) % N_CHAN;
         cidx = CHAN_BITS'(c);
         if (!found && fill_q[cidx] != '0) begin
            found = 1'b1;
            gnt   = cidx;
         end
      end
   end

   always_comb begin
      load   = !ov_q || bus.m_req_ready;
      push   = bus.s_req_valid & rdy_q;
      pop    = '0;
      ov_d   = ov_q;
      data_d = data_q;
      chan_d = chan_q;
      last_d = last_q;
      if (load) begin
         ov_d = found;
         if (found) begin
            pop[gnt] = 1'b1;
            data_d   = mem_q[gnt][rptr_q[gnt]];
            chan_d   = gnt;
            last_d   = gnt;
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < N_CHAN; i++) begin
         wptr_d[i] = wptr_q[i] + PTR_BITS'(push[i]);
         rptr_d[i] = rptr_q[i] + PTR_BITS'(pop[i]);
         fill_d[i] = fill_q[i] + CNT_BITS'(push[i]) - CNT_BITS'(pop[i]);
         rdy_d[i]  = fill_d[i] < CNT_BITS'(DEPTH);
         if (push[i])
            mem_d[i][wptr_q[i]] = bus.s_req_data[i*DATA_BITS +: DATA_BITS];
      end
   end

   always_ff @(posedge aclk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < N_CHAN; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
            fill_q[i] <= '0;
         end
         rdy_q  <= '0;
         ov_q   <= 1'b0;
         data_q <= '0;
         chan_q <= '0;
         last_q <= CHAN_BITS'(N_CHAN - 1);
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         fill_q <= fill_d;
         rdy_q  <= rdy_d;
         ov_q   <= ov_d;
         data_q <= data_d;
         chan_q <= chan_d;
         last_q <= last_d;
      end
   end

   assign bus.s_req_ready = rdy_q;
   assign bus.m_req_valid = ov_q;
   assign bus.m_req_data  = data_q;
   assign bus.m_req_chan  = chan_q;

   always_comb begin
      fifo_fill = '0;
      for (int i = 0; i < N_CHAN; i++)
         fifo_fill[i*CNT_BITS +: CNT_BITS] = fill_q[i];
   end

`ifdef RDMA_REQ_STATS_EN
   logic [31:0] stat_q [N_CHAN];
   logic [31:0] stat_d [N_CHAN];

   always_comb begin
      for (int i = 0; i < N_CHAN; i++)
         stat_d[i] = stat_q[i] + 32'(pop[i]);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < N_CHAN; i++)
            stat_q[i] <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   always_comb begin
      stat_grant_cnt = '0;
      for (int i = 0; i < N_CHAN; i++)
         stat_grant_cnt[i*32 +: 32] = stat_q[i];
   end
`else
   assign stat_grant_cnt = '0;
`endif
endmodule

// File: tb/tb_rdma_req_arb_ul.sv
// Vector table, directed corner sequences and a queue-model random run
// for rdma_req_arb_ul (default parameters).
module tb_rdma_req_arb_ul;
   localparam int N     = 4;
   localparam int DW    = 96;
   localparam int DEPTH = 8;
   localparam int CB    = 4;

`ifdef RDMA_REQ_STATS_EN
   localparam int EXP0 = 37;
   localparam int EXP3 = 5;
`else
   localparam int EXP0 = 0;
   localparam int EXP3 = 0;
`endif

   logic            aclk;
   logic            areset;
   logic [N*32-1:0] stat;
   logic [N*CB-1:0] fill;

   rdma_req_arb_ul_if #(.N_CHAN(N), .DATA_BITS(DW)) bus ();

   rdma_req_arb_ul #(
      .N_CHAN(N), .DATA_BITS(DW), .DEPTH(DEPTH)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .bus(bus),
      .stat_grant_cnt(stat),
      .fifo_fill(fill)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_data(input int ch, input logic [DW-1:0] v);
      bus.s_req_data[ch*DW +: DW] = v;
   endtask

   function automatic logic [CB-1:0] fill_of(input int i);
      return fill[i*CB +: CB];
   endfunction

   task automatic do_reset();
      areset = 1'b1;
      bus.s_req_valid = '0;
      bus.m_req_ready = 1'b0;
      tick();
      tick();
      areset = 1'b0;
      tick();
   endtask

   // Reference model: one queue per channel plus the output register.
   logic [DW-1:0] mq [N][$];
   logic          m_ov;
   logic [DW-1:0] m_data;
   int            m_chan;
   int            m_last;
   logic [N-1:0]  m_rdy;

   task automatic model_step(input logic rst);
      logic [N-1:0] psh;
      int g;
      if (rst) begin
         for (int i = 0; i < N; i++) mq[i].delete();
         m_ov   = 1'b0;
         m_data = '0;
         m_chan = 0;
         m_last = N - 1;
         m_rdy  = '0;
         return;
      end
      psh = bus.s_req_valid & m_rdy;
      if (!m_ov || bus.m_req_ready) begin
         g = -1;
         for (int k = 1; k <= N; k++)
            if (g < 0 && mq[(m_last + k) % N].size() > 0)
               g = (m_last + k) % N;
         m_ov = (g >= 0);
         if (g >= 0) begin
            m_data = mq[g].pop_front();
            m_chan = g;
            m_last = g;
         end
      end
      for (int i = 0; i < N; i++)
         if (psh[i]) mq[i].push_back(bus.s_req_data[i*DW +: DW]);
      for (int i = 0; i < N; i++)
         m_rdy[i] = (mq[i].size() < DEPTH);
   endtask

   typedef struct {
      logic [3:0]  vld;
      logic [31:0] dat;
      logic        mrdy;
      logic        exp_v;
      logic [1:0]  exp_c;
      logic [7:0]  exp_d;
      logic [3:0]  exp_r;
      logic [15:0] exp_f;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           sent;
      logic         rv;
      int           s0;
      int           s3;
      logic [N-1:0] rvv;
      logic         rst_now;

      tbl[0]  = '{4'b0100, 32'h005A0000, 1'b1, 1'b0, 2'd0, 8'h00, 4'hF, 16'h0100};
      tbl[1]  = '{4'b0000, 32'h00000000, 1'b1, 1'b1, 2'd2, 8'h5A, 4'hF, 16'h0000};
      tbl[2]  = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 2'd0, 8'h00, 4'hF, 16'h0000};
      tbl[3]  = '{4'b0010, 32'h00001100, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 16'h0010};
      tbl[4]  = '{4'b0000, 32'h00000000, 1'b0, 1'b1, 2'd1, 8'h11, 4'hF, 16'h0000};
      tbl[5]  = '{4'b1010, 32'h31001200, 1'b0, 1'b1, 2'd1, 8'h11, 4'hF, 16'h1010};
      tbl[6]  = '{4'b0000, 32'h00000000, 1'b1, 1'b1, 2'd3, 8'h31, 4'hF, 16'h0010};
      tbl[7]  = '{4'b0000, 32'h00000000, 1'b1, 1'b1, 2'd1, 8'h12, 4'hF, 16'h0000};
      tbl[8]  = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 2'd0, 8'h00, 4'hF, 16'h0000};
      tbl[9]  = '{4'b0001, 32'h000000A0, 1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 16'h0001};
      tbl[10] = '{4'b0001, 32'h000000A1, 1'b0, 1'b1, 2'd0, 8'hA0, 4'hF, 16'h0001};
      tbl[11] = '{4'b0000, 32'h00000000, 1'b1, 1'b1, 2'd0, 8'hA1, 4'hF, 16'h0000};
      tbl[12] = '{4'b0000, 32'h00000000, 1'b1, 1'b0, 2'd0, 8'h00, 4'hF, 16'h0000};

      areset = 1'b1;
      bus.s_req_valid = '0;
      bus.s_req_data  = '0;
      bus.m_req_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", 128'(bus.m_req_valid), 128'(0));
      chk("rst_data", 128'(bus.m_req_data), 128'(0));
      chk("rst_chan", 128'(bus.m_req_chan), 128'(0));
      chk("rst_ready", 128'(bus.s_req_ready), 128'(0));
      chk("rst_fill", 128'(fill), 128'(0));
      areset = 1'b0;
      tick();
      chk("rel_ready", 128'(bus.s_req_ready), 128'(4'hF));

      for (int r = 0; r < 13; r++) begin
         bus.s_req_valid = tbl[r].vld;
         for (int c = 0; c < N; c++) set_data(c, DW'(tbl[r].dat[c*8 +: 8]));
         bus.m_req_ready = tbl[r].mrdy;
         tick();
         chk($sformatf("vec%0d_valid", r), 128'(bus.m_req_valid), 128'(tbl[r].exp_v));
         if (tbl[r].exp_v) begin
            chk($sformatf("vec%0d_chan", r), 128'(bus.m_req_chan), 128'(tbl[r].exp_c));
            chk($sformatf("vec%0d_data", r), 128'(bus.m_req_data), 128'(tbl[r].exp_d));
         end
         chk($sformatf("vec%0d_ready", r), 128'(bus.s_req_ready), 128'(tbl[r].exp_r));
         chk($sformatf("vec%0d_fill", r), 128'(fill), 128'(tbl[r].exp_f));
      end

      // Two beats per channel, then round-robin drain at full rate.
      do_reset();
      for (int b = 0; b < 2; b++) begin
         bus.s_req_valid = 4'hF;
         for (int c = 0; c < N; c++) set_data(c, DW'(b * 16 + c));
         tick();
      end
      bus.s_req_valid = '0;
      chk("burst0_valid", 128'(bus.m_req_valid), 128'(1));
      chk("burst0_chan", 128'(bus.m_req_chan), 128'(0));
      chk("burst0_data", 128'(bus.m_req_data), 128'(0));
      bus.m_req_ready = 1'b1;
      for (int s = 1; s < 8; s++) begin
         tick();
         chk($sformatf("burst%0d_valid", s), 128'(bus.m_req_valid), 128'(1));
         chk($sformatf("burst%0d_chan", s), 128'(bus.m_req_chan), 128'(s % 4));
         chk($sformatf("burst%0d_data", s), 128'(bus.m_req_data),
             128'((s / 4) * 16 + (s % 4)));
      end
      tick();
      chk("burst_end_valid", 128'(bus.m_req_valid), 128'(0));

      // Backpressure: channel 1 streams into a stalled output.
      do_reset();
      sent = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         bus.s_req_valid = 4'b0010;
         set_data(1, DW'(256 + sent));
         rv = bus.s_req_ready[1];
         tick();
         if (rv) sent++;
      end
      bus.s_req_valid = '0;
      chk("bp_sent", 128'(sent), 128'(DEPTH + 1));
      chk("bp_fill1", 128'(fill_of(1)), 128'(DEPTH));
      chk("bp_ready1", 128'(bus.s_req_ready[1]), 128'(0));
      for (int s = 0; s < 2; s++) begin
         chk("bp_hold_valid", 128'(bus.m_req_valid), 128'(1));
         chk("bp_hold_chan", 128'(bus.m_req_chan), 128'(1));
         chk("bp_hold_data", 128'(bus.m_req_data), 128'(256));
         tick();
      end
      bus.m_req_ready = 1'b1;
      for (int j = 1; j <= DEPTH; j++) begin
         tick();
         if (j == 1) begin
            chk("bp_pop_fill1", 128'(fill_of(1)), 128'(DEPTH - 1));
            chk("bp_pop_ready1", 128'(bus.s_req_ready[1]), 128'(1));
         end
         chk($sformatf("bp_drain%0d_valid", j), 128'(bus.m_req_valid), 128'(1));
         chk($sformatf("bp_drain%0d_data", j), 128'(bus.m_req_data), 128'(256 + j));
      end
      tick();
      chk("bp_end_valid", 128'(bus.m_req_valid), 128'(0));

      // Reset in the middle of a burst drops everything.
      do_reset();
      for (int b = 0; b < 3; b++) begin
         bus.s_req_valid = (b < 2) ? 4'b0101 : 4'b0001;
         set_data(0, DW'(8'hE0 + b));
         set_data(2, DW'(8'hF0 + b));
         tick();
      end
      bus.s_req_valid = '0;
      chk("mid_pre_valid", 128'(bus.m_req_valid), 128'(1));
      areset = 1'b1;
      tick();
      chk("mid_rst_valid", 128'(bus.m_req_valid), 128'(0));
      chk("mid_rst_fill", 128'(fill), 128'(0));
      chk("mid_rst_ready", 128'(bus.s_req_ready), 128'(0));
      areset = 1'b0;
      bus.m_req_ready = 1'b1;
      for (int s = 0; s < 6; s++) begin
         tick();
         chk("mid_after_valid", 128'(bus.m_req_valid), 128'(0));
      end

      // Granted-beat counters: 37 beats on channel 0, 5 on channel 3.
      do_reset();
      bus.m_req_ready = 1'b1;
      s0 = 0;
      s3 = 0;
      for (int t = 0; t < 200 && (s0 < 37 || s3 < 5); t++) begin
         bus.s_req_valid = {(s3 < 5), 2'b00, (s0 < 37)};
         set_data(0, DW'(s0));
         set_data(3, DW'(s3));
         rvv = bus.s_req_ready & bus.s_req_valid;
         tick();
         if (rvv[0]) s0++;
         if (rvv[3]) s3++;
      end
      bus.s_req_valid = '0;
      chk("stat_sent0", 128'(s0), 128'(37));
      chk("stat_sent3", 128'(s3), 128'(5));
      for (int t = 0; t < 30; t++) tick();
      chk("stat_ch0", 128'(stat[0 +: 32]), 128'(EXP0));
      chk("stat_ch1", 128'(stat[32 +: 32]), 128'(0));
      chk("stat_ch2", 128'(stat[64 +: 32]), 128'(0));
      chk("stat_ch3", 128'(stat[96 +: 32]), 128'(EXP3));

      // Random traffic against the queue model.
      areset = 1'b1;
      bus.s_req_valid = '0;
      bus.m_req_ready = 1'b0;
      model_step(1'b1);
      tick();
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst_now = ($urandom_range(0, 99) == 0);
         areset = rst_now;
         bus.s_req_valid = 4'($urandom_range(0, 15));
         for (int c = 0; c < N; c++)
            set_data(c, {$urandom, $urandom, $urandom});
         if (cyc < 300) bus.m_req_ready = ($urandom_range(0, 3) != 0);
         else bus.m_req_ready = ($urandom_range(0, 3) == 0);
         model_step(rst_now);
         tick();
         chk("rnd_valid", 128'(bus.m_req_valid), 128'(m_ov));
         if (m_ov) begin
            chk("rnd_data", 128'(bus.m_req_data), 128'(m_data));
            chk("rnd_chan", 128'(bus.m_req_chan), 128'(m_chan));
         end
         chk("rnd_ready", 128'(bus.s_req_ready), 128'(m_rdy));
         for (int i = 0; i < N; i++)
            chk($sformatf("rnd_fill%0d", i), 128'(fill_of(i)), 128'(mq[i].size()));
      end
      areset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
